// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common-bus arbiter: default sizes, FSM encodings and a
// wrap-around index helper used by both round-robin pointers.
package com_bus_arbiter_pkg;

    localparam int NUM_CORES_DEF    = 4;
    localparam int OWNER_W_DEF      = 2;
    localparam int HOLD_TIMEOUT_DEF = 255;
    localparam int HOLD_CNT_W       = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PROC = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/com_bus_arbiter_if.sv
// Common-bus arbitration signals; the arbiter takes the master view, the cache
// wrappers the slave view.
interface com_bus_arbiter_if
    import com_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int OWNER_W   = OWNER_W_DEF
);
    logic [NUM_CORES-1:0] Com_Bus_Req_proc;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_proc;
    logic [NUM_CORES-1:0] Com_Bus_Req_snoop;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop;
    logic                 Invalidate;
    logic [NUM_CORES-1:0] Invalidation_done;
    logic                 All_Invalidation_done;
    logic [NUM_CORES-1:0] Shared_local;
    logic                 Shared;
    logic [OWNER_W-1:0]   Bus_owner;
    logic                 Bus_busy;
    logic                 Hold_timeout;

    modport master (
        input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidate, Invalidation_done, Shared_local,
        output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done, Shared,
               Bus_owner, Bus_busy, Hold_timeout
    );

    modport slave (
        output Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidate, Invalidation_done, Shared_local,
        input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done, Shared,
               Bus_owner, Bus_busy, Hold_timeout
    );
endinterface

// File: rtl/com_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping, returned as
// one-hot grant plus index. Purely combinational.
module com_bus_arbiter_rr_pick
    import com_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int OWNER_W   = OWNER_W_DEF
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [OWNER_W-1:0]   ptr_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output logic [OWNER_W-1:0]   idx_o,
    output logic                 valid_o
);
    logic found;
    int   pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            pos = (int'(ptr_i) + i) % NUM_CORES;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = OWNER_W'(pos);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin processor-side ownership with a dead TURN cycle between
// owners, one-at-a-time snoop grants during ownership, and global Shared/invalidation combine.
module com_bus_arbiter
    import com_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES    = NUM_CORES_DEF,
    parameter int OWNER_W      = OWNER_W_DEF,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    com_bus_arbiter_if.master bus
);
    logic [1:0]            state_q, state_d;
    logic [OWNER_W-1:0]    proc_ptr_q, proc_ptr_d;
    logic [OWNER_W-1:0]    snoop_ptr_q, snoop_ptr_d;
    logic [OWNER_W-1:0]    bus_owner_q, bus_owner_d;
    logic                  bus_busy_q, bus_busy_d;
    logic [NUM_CORES-1:0]  gnt_proc_q, gnt_proc_d;
    logic [NUM_CORES-1:0]  gnt_snoop_q, gnt_snoop_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  hold_timeout_q, hold_timeout_d;

    logic [NUM_CORES-1:0]  owner_oh;
    logic                  owner_req;
    logic                  grant_change;

    logic [NUM_CORES-1:0]  proc_pick_gnt, snoop_pick_gnt;
    logic [OWNER_W-1:0]    proc_pick_idx, snoop_pick_idx;
    logic                  proc_pick_valid, snoop_pick_valid;

    assign owner_oh  = NUM_CORES'(1) << bus_owner_q;
    assign owner_req = |(bus.Com_Bus_Req_proc & owner_oh);

    com_bus_arbiter_rr_pick #(.NUM_CORES(NUM_CORES), .OWNER_W(OWNER_W)) u_proc_pick (
        .req_i   (bus.Com_Bus_Req_proc),
        .ptr_i   (proc_ptr_q),
        .gnt_o   (proc_pick_gnt),
        .idx_o   (proc_pick_idx),
        .valid_o (proc_pick_valid)
    );

    // The owner never competes for a snoop grant on its own transaction.
    com_bus_arbiter_rr_pick #(.NUM_CORES(NUM_CORES), .OWNER_W(OWNER_W)) u_snoop_pick (
        .req_i   (bus.Com_Bus_Req_snoop & ~owner_oh),
        .ptr_i   (snoop_ptr_q),
        .gnt_o   (snoop_pick_gnt),
        .idx_o   (snoop_pick_idx),
        .valid_o (snoop_pick_valid)
    );

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch below can leave one unassigned and infer a latch.
        state_d        = state_q;
        proc_ptr_d     = proc_ptr_q;
        snoop_ptr_d    = snoop_ptr_q;
        bus_owner_d    = bus_owner_q;
        bus_busy_d     = bus_busy_q;
        gnt_proc_d     = gnt_proc_q;
        gnt_snoop_d    = gnt_snoop_q;
        hold_cnt_d     = hold_cnt_q;
        hold_timeout_d = hold_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (proc_pick_valid) begin
                    state_d     = ST_PROC;
                    gnt_proc_d  = proc_pick_gnt;
                    bus_owner_d = proc_pick_idx;
                    bus_busy_d  = 1'b1;
                end
            end
            ST_PROC: begin
                // Owner release takes priority over any snoop activity in the same cycle.
                if (!owner_req) begin
                    state_d     = ST_TURN;
                    gnt_proc_d  = '0;
                    gnt_snoop_d = '0;
                    bus_busy_d  = 1'b0;
                    proc_ptr_d  = OWNER_W'(wrap_inc(int'(bus_owner_q), NUM_CORES));
                end else if (|gnt_snoop_q) begin
                    if (!(|(gnt_snoop_q & bus.Com_Bus_Req_snoop)))
                        gnt_snoop_d = '0;
                end else if (snoop_pick_valid) begin
                    gnt_snoop_d = snoop_pick_gnt;
                    snoop_ptr_d = OWNER_W'(wrap_inc(int'(snoop_pick_idx), NUM_CORES));
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: begin
                state_d     = ST_IDLE;
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                bus_busy_d  = 1'b0;
            end
        endcase

        grant_change = (gnt_proc_d != gnt_proc_q) || (gnt_snoop_d != gnt_snoop_q);
        if (grant_change)
            hold_cnt_d = '0;
        else if ((|gnt_proc_q) && (hold_cnt_q != '1))
            hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);

        if (int'(hold_cnt_d) >= HOLD_TIMEOUT)
            hold_timeout_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            proc_ptr_q     <= '0;
            snoop_ptr_q    <= '0;
            bus_owner_q    <= '0;
            bus_busy_q     <= 1'b0;
            gnt_proc_q     <= '0;
            gnt_snoop_q    <= '0;
            hold_cnt_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            proc_ptr_q     <= proc_ptr_d;
            snoop_ptr_q    <= snoop_ptr_d;
            bus_owner_q    <= bus_owner_d;
            bus_busy_q     <= bus_busy_d;
            gnt_proc_q     <= gnt_proc_d;
            gnt_snoop_q    <= gnt_snoop_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    assign bus.Com_Bus_Gnt_proc      = gnt_proc_q;
    assign bus.Com_Bus_Gnt_snoop     = gnt_snoop_q;
    assign bus.Bus_owner             = bus_owner_q;
    assign bus.Bus_busy              = bus_busy_q;
    assign bus.Hold_timeout          = hold_timeout_q;
    assign bus.Shared                = bus_busy_q & (|(bus.Shared_local & ~owner_oh));
    assign bus.All_Invalidation_done = bus_busy_q & bus.Invalidate
                                       & (&(bus.Invalidation_done | owner_oh));

endmodule
